// File: rtl/affine_mcm_pipe.sv
// Two-stage shift-add multiple-constant multiplier (x * {11,10,9,8,5,4,3,2}) with valid/ready flow control.
// Optional clamping of each product to OUT_W bits is enabled by defining AFFINE_MCM_SAT_EN.
module affine_mcm_pipe #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int N_OUT  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x_i,
  input  logic                      neg_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*OUT_W-1:0]    y_o,
  output logic                      sat_o
);

  localparam int IW = DATA_W + 5;
`ifdef AFFINE_MCM_SAT_EN
  localparam int EW = (OUT_W > IW) ? OUT_W : IW;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  logic s1_valid, s2_valid, s1_neg;
  logic adv1, adv2;
  logic signed [IW-1:0] s1_w1, s1_w3, s1_w5, s1_w9, s1_w11;
  logic signed [IW-1:0] w1, w4, w8, w3, w5, w9, w11;
  logic signed [IW-1:0] mag [8];
  logic [N_OUT*OUT_W-1:0] y_next;
  logic sat_next;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_comb begin
    w1  = IW'(x_i);
    w4  = w1 <<< 2;
    w8  = w1 <<< 3;
    w3  = w4 - w1;
    w5  = w1 + w4;
    w9  = w1 + w8;
    w11 = w3 + w8;
  end

  // Magnitudes fit in IW bits, so negation of any of them cannot overflow.
  always_comb begin
    logic signed [IW-1:0] sv;
`ifdef AFFINE_MCM_SAT_EN
    logic signed [EW-1:0] ev;
`endif
    mag[0] = s1_w11;
    mag[1] = s1_w5 <<< 1;
    mag[2] = s1_w9;
    mag[3] = s1_w1 <<< 3;
    mag[4] = s1_w5;
    mag[5] = s1_w1 <<< 2;
    mag[6] = s1_w3;
    mag[7] = s1_w1 <<< 1;
    y_next   = '0;
    sat_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sv = s1_neg ? -mag[i] : mag[i];
`ifdef AFFINE_MCM_SAT_EN
      ev = EW'(sv);
      if (ev > MAX_V) begin
        y_next[i*OUT_W +: OUT_W] = MAX_V[OUT_W-1:0];
        sat_next = 1'b1;
      end else if (ev < MIN_V) begin
        y_next[i*OUT_W +: OUT_W] = MIN_V[OUT_W-1:0];
        sat_next = 1'b1;
      end else begin
        y_next[i*OUT_W +: OUT_W] = ev[OUT_W-1:0];
      end
`else
      y_next[i*OUT_W +: OUT_W] = OUT_W'(sv);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_w1    <= '0;
      s1_w3    <= '0;
      s1_w5    <= '0;
      s1_w9    <= '0;
      s1_w11   <= '0;
      y_o      <= '0;
      sat_o    <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_neg <= neg_i;
          s1_w1  <= w1;
          s1_w3  <= w3;
          s1_w5  <= w5;
          s1_w9  <= w9;
          s1_w11 <= w11;
        end
      end
      // y_o deliberately keeps its last value across bubbles.
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          y_o   <= y_next;
          sat_o <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_affine_mcm_pipe.sv
// Directed and random checks of affine_mcm_pipe at OUT_W=16 and OUT_W=10 sharing one input stream.
// Expectations for the narrow instance depend on whether AFFINE_MCM_SAT_EN is defined.
module tb_affine_mcm_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, neg, out_ready;
  logic signed [7:0] x;
  logic in_ready, out_valid, sat;
  logic [127:0] y;
  logic in_ready10, out_valid10, sat10;
  logic [79:0] y10;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  affine_mcm_pipe #(.DATA_W(8), .OUT_W(16), .N_OUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_i(x), .neg_i(neg),
    .out_valid(out_valid), .out_ready(out_ready), .y_o(y), .sat_o(sat));

  affine_mcm_pipe #(.DATA_W(8), .OUT_W(10), .N_OUT(8)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10), .x_i(x), .neg_i(neg),
    .out_valid(out_valid10), .out_ready(out_ready), .y_o(y10), .sat_o(sat10));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] y16(input int k);
    return $signed(y[k*16 +: 16]);
  endfunction

  function automatic logic signed [31:0] y10s(input int k);
    return $signed(y10[k*10 +: 10]);
  endfunction

  function automatic logic [127:0] golden(input int xv, input bit ng);
    int c [8] = '{11, 10, 9, 8, 5, 4, 3, 2};
    logic [127:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = ng ? -(c[k] * xv) : c[k] * xv;
      r[k*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  typedef struct { int xv; bit ng; } samp_t;
  samp_t q [$];

  initial begin
    int e1 [8] = '{-11, -10, -9, -8, -5, -4, -3, -2};
    int e2 [8] = '{1408, 1280, 1152, 1024, 640, 512, 384, 256};
    bit sat_on;
    int timeout;
    samp_t s;
`ifdef AFFINE_MCM_SAT_EN
    sat_on = 1'b1;
`else
    sat_on = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; x = '0; neg = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk_vec("reset y_o", y, '0);
    chk("reset sat_o", sat, 0);
    chk("reset in_ready", in_ready, 1);

    // basic magnitudes, negated
    in_valid = 1'b1; x = 8'sd1; neg = 1'b1;
    step();
    in_valid = 1'b0;
    chk("basic out_valid cycle1", out_valid, 0);
    step();
    chk("basic out_valid cycle2", out_valid, 1);
    for (int k = 0; k < 8; k++) chk($sformatf("basic Y%0d", k + 1), y16(k), e1[k]);
    chk("basic sat", sat, 0);
    step();
    chk("bubble out_valid", out_valid, 0);
    chk("bubble y_o held", y16(0), -11);

    // extremes, back to back
    in_valid = 1'b1; x = -8'sd128; neg = 1'b1;
    step();
    x = 8'sd127; neg = 1'b0;
    step();
    in_valid = 1'b0;
    chk("ext1 out_valid", out_valid, 1);
    for (int k = 0; k < 8; k++) chk($sformatf("ext1 Y%0d", k + 1), y16(k), e2[k]);
    chk("ext1 sat16", sat, 0);
    chk("ext1 w10 Y1", y10s(0), sat_on ? 511 : 384);
    chk("ext1 w10 Y8", y10s(7), 256);
    chk("ext1 w10 sat", sat10, sat_on ? 1 : 0);
    step();
    chk("ext2 out_valid", out_valid, 1);
    chk("ext2 Y1", y16(0), 1397);
    chk("ext2 Y8", y16(7), 254);
    chk("ext2 w10 Y1", y10s(0), sat_on ? 511 : 373);
    chk("ext2 w10 Y8", y10s(7), 254);
    chk("ext2 w10 sat", sat10, sat_on ? 1 : 0);
    step();

    // backpressure
    out_ready = 1'b0; neg = 1'b0;
    in_valid = 1'b1; x = 8'sd1;
    #1; chk("bp ready first", in_ready, 1);
    step();
    x = 8'sd2;
    step();
    x = 8'sd3;
    chk("bp in_ready low", in_ready, 0);
    chk("bp Y1 first", y16(0), 11);
    step(); step();
    chk("bp stall out_valid", out_valid, 1);
    chk("bp stall Y1", y16(0), 11);
    chk("bp stall in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1; chk("bp ready comb", in_ready, 1);
    step();
    chk("bp out2", y16(0), 22);
    chk("bp out2 valid", out_valid, 1);
    x = 8'sd4;
    step();
    in_valid = 1'b0;
    chk("bp out3", y16(0), 33);
    chk("bp out3 valid", out_valid, 1);
    step();
    chk("bp out4", y16(0), 44);
    chk("bp out4 valid", out_valid, 1);
    step();
    chk("bp drained", out_valid, 0);

    // reset mid-stream
    in_valid = 1'b1; x = 8'sd5;
    step();
    x = 8'sd6; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk_vec("rst y_o", y, '0);
    chk("rst in_ready", in_ready, 1);
    step();
    chk("rst no stale 1", out_valid, 0);
    step();
    chk("rst no stale 2", out_valid, 0);

    // random soak against a multiply-based model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x   = 8'($urandom);
      neg = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("soak spurious output", 1, 0);
        else begin
          s = q.pop_front();
          chk_vec("soak y_o", y, golden(s.xv, s.ng));
        end
      end
      if (in_valid && in_ready) q.push_back('{int'(x), neg});
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    timeout = 0;
    #1;
    while (q.size() != 0 && timeout < 10) begin
      if (out_valid) begin
        s = q.pop_front();
        chk_vec("drain y_o", y, golden(s.xv, s.ng));
      end
      step();
      #1;
      timeout++;
    end
    chk("soak leftover samples", q.size(), 0);
    chk("soak final out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
